// File: rtl/decbuf_pkg.sv
// Shared decode constants: instruction IDs, opcode/func/rs/rt match
// values and class-flag bit positions for the decode buffer.
package decbuf_pkg;

  localparam int ID_W_DEF = 6;

  typedef logic [5:0] id_t;
  typedef logic [5:0] cls_t;

  localparam id_t ID_ERR     = 6'd0;
  localparam id_t ID_ADDU    = 6'd1;
  localparam id_t ID_SUBU    = 6'd2;
  localparam id_t ID_ADD     = 6'd3;
  localparam id_t ID_SUB     = 6'd4;
  localparam id_t ID_AND     = 6'd5;
  localparam id_t ID_OR      = 6'd6;
  localparam id_t ID_XOR     = 6'd7;
  localparam id_t ID_NOR     = 6'd8;
  localparam id_t ID_SLL     = 6'd9;
  localparam id_t ID_SRL     = 6'd10;
  localparam id_t ID_SRA     = 6'd11;
  localparam id_t ID_SLLV    = 6'd12;
  localparam id_t ID_SRLV    = 6'd13;
  localparam id_t ID_SRAV    = 6'd14;
  localparam id_t ID_SLT     = 6'd15;
  localparam id_t ID_SLTU    = 6'd16;
  localparam id_t ID_JR      = 6'd17;
  localparam id_t ID_JALR    = 6'd18;
  localparam id_t ID_MULT    = 6'd19;
  localparam id_t ID_MULTU   = 6'd20;
  localparam id_t ID_DIV     = 6'd21;
  localparam id_t ID_DIVU    = 6'd22;
  localparam id_t ID_MFHI    = 6'd23;
  localparam id_t ID_MFLO    = 6'd24;
  localparam id_t ID_MTHI    = 6'd25;
  localparam id_t ID_MTLO    = 6'd26;
  localparam id_t ID_SYSCALL = 6'd27;
  localparam id_t ID_BLTZ    = 6'd28;
  localparam id_t ID_BGEZ    = 6'd29;
  localparam id_t ID_MFC0    = 6'd30;
  localparam id_t ID_MTC0    = 6'd31;
  localparam id_t ID_ERET    = 6'd32;
  localparam id_t ID_LB      = 6'd33;
  localparam id_t ID_LBU     = 6'd34;
  localparam id_t ID_LH      = 6'd35;
  localparam id_t ID_LHU     = 6'd36;
  localparam id_t ID_LW      = 6'd37;
  localparam id_t ID_SB      = 6'd38;
  localparam id_t ID_SH      = 6'd39;
  localparam id_t ID_SW      = 6'd40;
  localparam id_t ID_BEQ     = 6'd41;
  localparam id_t ID_BNE     = 6'd42;
  localparam id_t ID_BLEZ    = 6'd43;
  localparam id_t ID_BGTZ    = 6'd44;
  localparam id_t ID_ADDI    = 6'd45;
  localparam id_t ID_ADDIU   = 6'd46;
  localparam id_t ID_ANDI    = 6'd47;
  localparam id_t ID_ORI     = 6'd48;
  localparam id_t ID_XORI    = 6'd49;
  localparam id_t ID_LUI     = 6'd50;
  localparam id_t ID_SLTI    = 6'd51;
  localparam id_t ID_SLTIU   = 6'd52;
  localparam id_t ID_J       = 6'd53;
  localparam id_t ID_JAL     = 6'd54;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SLLV    = 6'h04;
  localparam logic [5:0] F_SRLV    = 6'h06;
  localparam logic [5:0] F_SRAV    = 6'h07;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_JALR    = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0c;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MTHI    = 6'h11;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_MTLO    = 6'h13;
  localparam logic [5:0] F_MULT    = 6'h18;
  localparam logic [5:0] F_MULTU   = 6'h19;
  localparam logic [5:0] F_DIV     = 6'h1a;
  localparam logic [5:0] F_DIVU    = 6'h1b;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2a;
  localparam logic [5:0] F_SLTU    = 6'h2b;
  localparam logic [5:0] F_ERET    = 6'h18;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;
  localparam logic [4:0] RS_MFC0 = 5'd0;
  localparam logic [4:0] RS_MTC0 = 5'd4;

  localparam int CLS_LOAD   = 5;
  localparam int CLS_STORE  = 4;
  localparam int CLS_BRANCH = 3;
  localparam int CLS_JUMP   = 2;
  localparam int CLS_MD     = 1;
  localparam int CLS_CP0    = 0;

endpackage

// File: rtl/decbuf_decode.sv
// Combinational instruction decoder: raw word to instruction ID and
// class flags. Shared with the E-stage delay-slot check.
module decbuf_decode
  import decbuf_pkg::*;
(
  input  logic [31:0] instr_i,
  output id_t         id_o,
  output cls_t        cls_o
);

  logic [5:0] op;
  logic [5:0] func;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       unused_bits;

  assign op   = instr_i[31:26];
  assign rs   = instr_i[25:21];
  assign rt   = instr_i[20:16];
  assign func = instr_i[5:0];
  assign unused_bits = ^instr_i[15:6];

  always_comb begin
    id_o = ID_ERR;
    case (op)
      OP_SPECIAL: begin
        case (func)
          F_SLL:     id_o = ID_SLL;
          F_SRL:     id_o = ID_SRL;
          F_SRA:     id_o = ID_SRA;
          F_SLLV:    id_o = ID_SLLV;
          F_SRLV:    id_o = ID_SRLV;
          F_SRAV:    id_o = ID_SRAV;
          F_JR:      id_o = ID_JR;
          F_JALR:    id_o = ID_JALR;
          F_SYSCALL: id_o = ID_SYSCALL;
          F_MFHI:    id_o = ID_MFHI;
          F_MTHI:    id_o = ID_MTHI;
          F_MFLO:    id_o = ID_MFLO;
          F_MTLO:    id_o = ID_MTLO;
          F_MULT:    id_o = ID_MULT;
          F_MULTU:   id_o = ID_MULTU;
          F_DIV:     id_o = ID_DIV;
          F_DIVU:    id_o = ID_DIVU;
          F_ADD:     id_o = ID_ADD;
          F_ADDU:    id_o = ID_ADDU;
          F_SUB:     id_o = ID_SUB;
          F_SUBU:    id_o = ID_SUBU;
          F_AND:     id_o = ID_AND;
          F_OR:      id_o = ID_OR;
          F_XOR:     id_o = ID_XOR;
          F_NOR:     id_o = ID_NOR;
          F_SLT:     id_o = ID_SLT;
          F_SLTU:    id_o = ID_SLTU;
          default:   id_o = ID_ERR;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ)      id_o = ID_BLTZ;
        else if (rt == RT_BGEZ) id_o = ID_BGEZ;
      end
      OP_COP0: begin
        if (rs == RS_MFC0)      id_o = ID_MFC0;
        else if (rs == RS_MTC0) id_o = ID_MTC0;
        else if (func == F_ERET) id_o = ID_ERET;
      end
      OP_J:     id_o = ID_J;
      OP_JAL:   id_o = ID_JAL;
      OP_BEQ:   id_o = ID_BEQ;
      OP_BNE:   id_o = ID_BNE;
      OP_BLEZ:  id_o = ID_BLEZ;
      OP_BGTZ:  id_o = ID_BGTZ;
      OP_ADDI:  id_o = ID_ADDI;
      OP_ADDIU: id_o = ID_ADDIU;
      OP_SLTI:  id_o = ID_SLTI;
      OP_SLTIU: id_o = ID_SLTIU;
      OP_ANDI:  id_o = ID_ANDI;
      OP_ORI:   id_o = ID_ORI;
      OP_XORI:  id_o = ID_XORI;
      OP_LUI:   id_o = ID_LUI;
      OP_LB:    id_o = ID_LB;
      OP_LH:    id_o = ID_LH;
      OP_LW:    id_o = ID_LW;
      OP_LBU:   id_o = ID_LBU;
      OP_LHU:   id_o = ID_LHU;
      OP_SB:    id_o = ID_SB;
      OP_SH:    id_o = ID_SH;
      OP_SW:    id_o = ID_SW;
      default:  id_o = ID_ERR;
    endcase
  end

  always_comb begin
    cls_o = '0;
    unique case (1'b1)
      id_o inside {ID_LB, ID_LBU, ID_LH, ID_LHU, ID_LW}:
        cls_o[CLS_LOAD] = 1'b1;
      id_o inside {ID_SB, ID_SH, ID_SW}:
        cls_o[CLS_STORE] = 1'b1;
      id_o inside {ID_BEQ, ID_BNE, ID_BLEZ, ID_BGTZ,
                   ID_BLTZ, ID_BGEZ}:
        cls_o[CLS_BRANCH] = 1'b1;
      id_o inside {ID_J, ID_JAL, ID_JR, ID_JALR}:
        cls_o[CLS_JUMP] = 1'b1;
      id_o inside {ID_MULT, ID_MULTU, ID_DIV, ID_DIVU,
                   ID_MFHI, ID_MFLO, ID_MTHI, ID_MTLO}:
        cls_o[CLS_MD] = 1'b1;
      id_o inside {ID_MFC0, ID_MTC0, ID_ERET, ID_SYSCALL}:
        cls_o[CLS_CP0] = 1'b1;
      default: cls_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_buffer.sv
// Fetch-side FIFO plus registered decode output stage.
// Define DECBUF_RI_EN to flag unknown encodings on out_ri.
module decode_buffer
  import decbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = ID_W_DEF,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [ID_W-1:0]          out_id,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_sa,
  output logic [15:0]              out_imm,
  output logic [25:0]              out_idx,
  output logic [5:0]               out_cls,
  output logic                     out_ri,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     instr_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q    [DEPTH];

  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  id_t             out_id_q, out_id_d;
  cls_t            out_cls_q, out_cls_d;

  logic            push, pop;
  id_t             head_id;
  cls_t            head_cls;

  // in_ready depends only on registered count, never on out_ready
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count_q != '0) && (!out_valid_q || out_ready);

  decbuf_decode u_dec (
    .instr_i (instr_mem_q[head_q]),
    .id_o    (head_id),
    .cls_o   (head_cls)
  );

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_id_d    = out_id_q;
    out_cls_d   = out_cls_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (pop) begin
      out_valid_d = 1'b1;
      out_instr_d = instr_mem_q[head_q];
      out_pc_d    = pc_mem_q[head_q];
      out_id_d    = head_id;
      out_cls_d   = head_cls;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_id_q    <= ID_ERR;
      out_cls_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_id_q    <= out_id_d;
      out_cls_q   <= out_cls_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem_q[tail_q] <= in_instr;
      pc_mem_q[tail_q]    <= in_pc;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_id    = ID_W'(out_id_q);
  assign out_rs    = out_instr_q[25:21];
  assign out_rt    = out_instr_q[20:16];
  assign out_rd    = out_instr_q[15:11];
  assign out_sa    = out_instr_q[10:6];
  assign out_imm   = out_instr_q[15:0];
  assign out_idx   = out_instr_q[25:0];
  assign count     = count_q;

`ifdef DECBUF_RI_EN
  assign out_ri  = (out_id_q == ID_ERR) && out_valid_q;
  assign out_cls = out_ri ? '0 : out_cls_q;
`else
  assign out_ri  = 1'b0;
  assign out_cls = out_cls_q;
`endif

endmodule

// File: tb/tb_decode_buffer.sv
// Directed bench for decode_buffer: decode vector table plus
// fill/drain, wrap, flush and async reset sequences.
module tb_decode_buffer;

  localparam int DEPTH = 4;
  localparam int ID_W  = 6;
  localparam int PC_W  = 32;
`ifdef DECBUF_RI_EN
  localparam bit RI_EN = 1'b1;
`else
  localparam bit RI_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, in_ready;
  logic            out_valid, out_ready, out_ri;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [ID_W-1:0] out_id;
  logic [4:0]      out_rs, out_rt, out_rd, out_sa;
  logic [15:0]     out_imm;
  logic [25:0]     out_idx;
  logic [5:0]      out_cls;
  logic [2:0]      count;

  decode_buffer #(.DEPTH(DEPTH), .ID_W(ID_W), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_id(out_id),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_sa(out_sa), .out_imm(out_imm), .out_idx(out_idx),
    .out_cls(out_cls), .out_ri(out_ri), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  id;
    logic [5:0]  cls;
    logic        err;
  } vec_t;

  vec_t            vt [17];
  int              ec [6];
  int              er [6];
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [PC_W-1:0] exp_q [$];
  int              k;
  logic            acc;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock with a PC-order scoreboard on both handshakes
  task automatic cyc();
    logic a, d;
    a = in_valid && in_ready && !flush;
    d = out_valid && out_ready && !flush;
    if (d) begin
      if (exp_q.size() == 0) chk("unexpected_out", out_valid, 0);
      else chk("order_pc", out_pc, exp_q.pop_front());
    end
    if (a) exp_q.push_back(in_pc);
    @(posedge clk);
    #1;
    if (flush) exp_q.delete();
  endtask

  function automatic logic [31:0] addu_rd(input int r);
    logic [4:0] rd;
    rd = r[4:0];
    return {6'd0, 5'd1, 5'd2, rd, 5'd0, 6'h21};
  endfunction

  initial begin
    vt[0]  = '{32'h00221821, 6'd1,  6'b000000, 1'b0};
    vt[1]  = '{32'h8C430004, 6'd37, 6'b100000, 1'b0};
    vt[2]  = '{32'h04110003, 6'd0,  6'b000000, 1'b1};
    vt[3]  = '{32'hAC430008, 6'd40, 6'b010000, 1'b0};
    vt[4]  = '{32'h10220005, 6'd41, 6'b001000, 1'b0};
    vt[5]  = '{32'h04010002, 6'd29, 6'b001000, 1'b0};
    vt[6]  = '{32'h08000010, 6'd53, 6'b000100, 1'b0};
    vt[7]  = '{32'h03E00008, 6'd17, 6'b000100, 1'b0};
    vt[8]  = '{32'h00430018, 6'd19, 6'b000010, 1'b0};
    vt[9]  = '{32'h00001010, 6'd23, 6'b000010, 1'b0};
    vt[10] = '{32'h0000000C, 6'd27, 6'b000001, 1'b0};
    vt[11] = '{32'h40026000, 6'd30, 6'b000001, 1'b0};
    vt[12] = '{32'h42000018, 6'd32, 6'b000001, 1'b0};
    vt[13] = '{32'h3C011234, 6'd50, 6'b000000, 1'b0};
    vt[14] = '{32'hFC000000, 6'd0,  6'b000000, 1'b1};
    vt[15] = '{32'h0000003F, 6'd0,  6'b000000, 1'b1};
    vt[16] = '{32'h00000000, 6'd9,  6'b000000, 1'b0};
    ec = '{1, 1, 2, 3, 4, 4};
    er = '{1, 1, 1, 1, 0, 0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_pc = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_id", out_id, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // addu: one push, presented after the following edge
    in_valid = 1'b1; in_instr = 32'h00221821; in_pc = 32'h1000;
    cyc();
    in_valid = 1'b0;
    chk("addu_lat0", out_valid, 0);
    cyc();
    chk("addu_valid", out_valid, 1);
    chk("addu_id", out_id, 1);
    chk("addu_rs", out_rs, 1);
    chk("addu_rt", out_rt, 2);
    chk("addu_rd", out_rd, 3);
    chk("addu_sa", out_sa, 0);
    chk("addu_cls", out_cls, 0);

    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_instr = vt[i].instr; in_pc = 32'h2000 + 4 * i;
      cyc();
      in_valid = 1'b0;
      cyc();
      chk("vec_valid", out_valid, 1);
      chk("vec_id", out_id, vt[i].id);
      chk("vec_cls", out_cls, vt[i].cls);
      chk("vec_ri", out_ri, RI_EN && vt[i].err);
      chk("vec_imm", out_imm, vt[i].instr[15:0]);
      chk("vec_idx", out_idx, vt[i].instr[25:0]);
    end
    cyc();
    chk("idle_valid", out_valid, 0);

    // Fill with the output stage stalled: 5 accepted, 6th refused
    out_ready = 1'b0; k = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_instr = addu_rd(k); in_pc = 32'h300 + 4 * k;
      acc = in_ready;
      cyc();
      if (acc) k++;
      chk("fill_count", count, ec[c]);
      chk("fill_ready", in_ready, er[c]);
    end
    chk("fill_head_pc", out_pc, 32'h300);

    // Stream through: count holds while pointers wrap
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1; in_instr = addu_rd(k); in_pc = 32'h300 + 4 * k;
      acc = in_ready;
      cyc();
      if (acc) k++;
      chk("stream_count", count, 3);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 12 && (exp_q.size() != 0 || out_valid); c++)
      cyc();
    chk("drain_left", exp_q.size(), 0);
    chk("drain_count", count, 0);
    chk("drain_valid", out_valid, 0);

    // Flush with count==3 and an instruction on offer
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_instr = addu_rd(c); in_pc = 32'h400 + 4 * c;
      cyc();
    end
    chk("preflush_count", count, 3);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'hDEAD0000;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("flush_noout", out_valid, 0);
    end

    // Asynchronous reset between edges
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_instr = 32'h8C430004; in_pc = 32'h500 + 4 * c;
      cyc();
    end
    #3;
    reset = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_id", out_id, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_rd", out_rd, 0);
    chk("arst_cls", out_cls, 0);
    chk("arst_ri", out_ri, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    chk("arst_ready", in_ready, 1);
    in_valid = 1'b1; in_instr = 32'h8C430004; in_pc = 32'h600;
    cyc();
    in_valid = 1'b0;
    chk("post_count", count, 1);
    chk("post_lat0", out_valid, 0);
    cyc();
    chk("post_valid", out_valid, 1);
    chk("post_id", out_id, 37);
    chk("post_pc", out_pc, 32'h600);
    chk("post_cls", out_cls, 6'b100000);
    cyc();
    chk("post_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
